// File: rtl/servo_count_if.sv
// Servo capture bus: two pulse inputs, scan request and serial result output.
interface servo_count_if;
  logic in0;
  logic in1;
  logic scan_en;
  logic scan_out;

  modport master (output in0, output in1, output scan_en, input scan_out);
  modport slave  (input in0, input in1, input scan_en, output scan_out);
endinterface

// File: rtl/servo_count.sv
// Two-channel servo pulse-width counter with a 28-bit serial scan-out of the latest results.
// Macro SERVOCOUNT_SYNC_EN enables the 2-flop input synchronizers; undefined, inputs feed edge detect directly.
module servo_count (
  input  logic          clk,
  input  logic          rst_n,
  servo_count_if.slave  bus
);
  localparam int unsigned CNT_W   = 14;
  localparam int unsigned FRAME_W = 2 * CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]            pin;
  logic [1:0]            lvl;
  logic [1:0]            lvl_d;
  logic [1:0]            fall;
  logic [1:0][CNT_W-1:0] cnt;
  logic [1:0][CNT_W-1:0] res;
  logic                  scan_en_d;
  logic [FRAME_W-1:0]    scan_sr;

  assign pin = {bus.in1, bus.in0};

`ifdef SERVOCOUNT_SYNC_EN
  logic [1:0] sync1;
  logic [1:0] sync2;

  // Metastability guard for the asynchronous servo inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  assign lvl = sync2;
`else
  assign lvl = pin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_d <= '0;
    else        lvl_d <= lvl;
  end

  assign fall = lvl_d & ~lvl;

  // Width counters; a falling edge latches the count and restarts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      res <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (fall[i]) begin
          res[i] <= cnt[i];
          cnt[i] <= '0;
        end else if (lvl[i] && (cnt[i] != CNT_MAX)) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Snapshot on scan_en rise, shift while held, clear when dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_en_d <= 1'b0;
      scan_sr   <= '0;
    end else begin
      scan_en_d <= bus.scan_en;
      if (!bus.scan_en)
        scan_sr <= '0;
      else if (!scan_en_d)
        scan_sr <= {res[0], res[1]};
      else
        scan_sr <= {scan_sr[FRAME_W-2:0], 1'b0};
    end
  end

  assign bus.scan_out = scan_sr[FRAME_W-1];
endmodule

// File: tb/tb_servo_count.sv
// Directed scoreboard bench for servo_count: expected scan bits are queued per frame and popped per cycle.
`timescale 1ns/1ps
module tb_servo_count;
  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  logic exp_q[$];

`ifdef SERVOCOUNT_SYNC_EN
  localparam int FALL_LAT = 3;
`else
  localparam int FALL_LAT = 1;
`endif

  always #5 clk = ~clk;

  servo_count_if bus();

  servo_count dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [13:0] r0, input logic [13:0] r1);
    logic [27:0] f;
    f = {r0, r1};
    for (int i = 27; i >= 0; i--) exp_q.push_back(f[i]);
  endtask

  task automatic scan(input string tag, input int n);
    logic e;
    bus.scan_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
      check($sformatf("%s_bit%0d", tag, 27 - i), bus.scan_out, e);
    end
  endtask

  // Full 28-bit frame, then one more cycle held high (must read 0), then idle
  task automatic scan_full(input string tag);
    scan(tag, 28);
    tick();
    check({tag, "_tail"}, bus.scan_out, 1'b0);
    bus.scan_en = 1'b0;
    tick();
    check({tag, "_idle"}, bus.scan_out, 1'b0);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.in0     = 1'b0;
    bus.in1     = 1'b0;
    bus.scan_en = 1'b0;
    tick(3);
    check("reset", bus.scan_out, 1'b0);
    rst_n = 1'b1;
    tick(2);

    // Empty frame straight after reset
    push_frame(14'd0, 14'd0);
    scan_full("zero");

    // Overlapping pulses: in0 1835 cycles, in1 240 cycles starting 120 before in0 falls
    bus.in0 = 1'b1;
    tick(1715);
    bus.in1 = 1'b1;
    tick(120);
    bus.in0 = 1'b0;
    tick(120);
    bus.in1 = 1'b0;
    tick(2000);
    push_frame(14'd1835, 14'd240);
    scan_full("pulse");

    // Rescan without new pulses repeats the frame
    push_frame(14'd1835, 14'd240);
    scan_full("rescan");

    // Over-long pulse saturates channel 1 only
    bus.in1 = 1'b1;
    tick(20000);
    bus.in1 = 1'b0;
    tick(10);
    push_frame(14'd1835, 14'd16383);
    scan_full("sat");

    // Aborted frame, one idle cycle, then a fresh complete frame
    push_frame(14'd1835, 14'd16383);
    scan("abort", 10);
    exp_q.delete();
    bus.scan_en = 1'b0;
    tick();
    check("abort_gap", bus.scan_out, 1'b0);
    push_frame(14'd1835, 14'd16383);
    scan_full("restart");

    // Falling edge detected on the same cycle as the snapshot load: old value captured
    bus.in0 = 1'b1;
    tick(50);
    bus.in0 = 1'b0;
    tick(FALL_LAT - 1);
    push_frame(14'd1835, 14'd16383);
    scan_full("coincide_old");
    push_frame(14'd50, 14'd16383);
    scan_full("coincide_new");

    // Input high across reset release: count from the synchronized level, latch on fall
    rst_n   = 1'b0;
    bus.in0 = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(40);
    bus.in0 = 1'b0;
    tick(5);
    push_frame(14'd40, 14'd0);
    scan_full("post_reset");

    // Reset mid-pulse and mid-scan
    bus.in0 = 1'b1;
    bus.in1 = 1'b1;
    tick(30);
    bus.scan_en = 1'b1;
    tick(5);
    rst_n = 1'b0;
    #1;
    check("rst_mid_scan", bus.scan_out, 1'b0);
    bus.in0     = 1'b0;
    bus.in1     = 1'b0;
    bus.scan_en = 1'b0;
    tick(2);
    check("rst_held", bus.scan_out, 1'b0);
    rst_n = 1'b1;
    tick(5);
    push_frame(14'd0, 14'd0);
    scan_full("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/servo_count.md
SERVO_COUNT -- requirements
Module: servo_count

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock, nominal 1 MHz so one count = 1 us.
REQ-002 rst_n input 1: asynchronous, active-low reset.
REQ-003 in0 input 1: servo pulse channel 0, asynchronous to clk, active high.
REQ-004 in1 input 1: servo pulse channel 1, asynchronous to clk, active high.
REQ-005 scan_en input 1: scan request; rising edge snapshots results, level high shifts.
REQ-006 scan_out output 1: serial result data, MSB first.
REQ-007 The block SHALL have no parameters; counter width is fixed at 14 bits per channel and the scan frame at 28 bits.

Function
REQ-008 Each channel SHALL pass its input through a 2-flop synchronizer, then a third flop for edge detection.
REQ-009 Each channel SHALL have a 14-bit width counter that increments on every clk edge where the synchronized input is 1.
REQ-010 The width counter SHALL saturate at 16383 and never wrap.
REQ-011 On a synchronized falling edge, the channel SHALL copy its counter into a 14-bit result register and clear the counter in the same cycle.
REQ-012 A synchronized rising edge SHALL start counting from 0; a pulse of N whole clk periods SHALL yield result N, or N±1 for unaligned edges.
REQ-013 Each result register SHALL hold its value until the next falling edge on its channel; scanning SHALL NOT clear it.
REQ-014 The block SHALL keep a 28-bit shift register, scan_sr, and a registered copy of scan_en, scan_en_d.
REQ-015 On a cycle with scan_en=1 and scan_en_d=0, scan_sr SHALL load {result0[13:0], result1[13:0]}.
REQ-016 On each later cycle with scan_en=1, scan_sr SHALL shift left by 1 with 0 shifted in.
REQ-017 On a cycle with scan_en=0, scan_sr SHALL be cleared to 0.
REQ-018 scan_out SHALL equal scan_sr[27] (registered, no combinational path from inputs).
REQ-019 result0 bit13 SHALL appear on scan_out the cycle after the load, followed by the remaining 27 bits on consecutive cycles; after 28 bits scan_out SHALL be 0.
REQ-020 If scan_en drops mid-frame, the frame SHALL be aborted; the next rising edge starts a fresh snapshot.
REQ-021 If a falling edge coincides with a snapshot load, the snapshot SHALL capture the old result; the new result SHALL appear in the next scan.
REQ-022 Channels SHALL be fully independent; overlapping pulses SHALL be measured concurrently.
REQ-023 scan_en SHALL be treated as synchronous to clk.

Reset
REQ-024 While rst_n=0, all synchronizer flops, counters, result registers, scan_en_d and scan_sr SHALL be 0, and scan_out SHALL be 0.
REQ-025 After reset release, an input already high SHALL NOT produce a rising edge; its count SHALL start from the synchronized level, and its falling edge SHALL latch the partial count.

Configuration
REQ-026 The macro SERVOCOUNT_SYNC_EN SHALL control the input synchronizers.
REQ-027 With SERVOCOUNT_SYNC_EN defined, the 2-flop synchronizers SHALL be present, giving 3-cycle edge-to-count latency.
REQ-028 Without SERVOCOUNT_SYNC_EN, in0 and in1 SHALL feed the edge-detect flop directly, giving 1-cycle latency, for use with already-synchronous sources; results SHALL be identical for aligned pulses.

Verification
REQ-029 Reset, then scan_en high for 28 cycles -> scan_out 0 for all 28 bits.
REQ-030 in0 high 1835 us with in1 high for its last 120 us and then 120 us more (240 us total), then 2 ms idle, then scan for 28 cycles -> bits decode to 1835 (0x72B)±1 and 240 (0x0F0)±1.
REQ-031 Rescan with no new pulses -> same 28-bit frame repeated.
REQ-032 in1 held high 20000 us then released, then scan -> result1 = 16383, result0 unchanged.
REQ-033 scan_en high 10 cycles, low 1 cycle, high 28 cycles -> second frame complete and correct from bit 27.
REQ-034 Assert rst_n=0 mid-pulse and mid-scan -> scan_out 0 immediately; subsequent scan reads 0, 0.
